rgb_line_sequencer: RTL

- Per-line illumination sequencer. It generates the START / END / RGB phase strobes consumed by the RGB LED PWM driver.
- On each line trigger it walks the enabled colours in fixed order R, G, B. Each colour gets a one-hot RGB select, a START pulse, an exposure window of programmed length, and an END pulse, with a guard gap between colours.
- Sits between the line-timing/trigger logic and the LED PWM driver. Reports BUSY and LINE_DONE back to the trigger source.

---
 rtl/rgb_line_sequencer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/rgb_line_sequencer.sv
// Per-line R/G/B illumination sequencer producing START/END/RGB strobes for the LED PWM driver.
// Optional build macro TRIG_OVERRUN_EN adds a sticky trigger-overrun flag and saturating counter.
module rgb_line_sequencer #(
  parameter int CNT_W    = 16,
  parameter int GAP_CLKS = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             LINE_TRIG,
  input  logic [CNT_W-1:0] EXP_R,
  input  logic [CNT_W-1:0] EXP_G,
  input  logic [CNT_W-1:0] EXP_B,
  input  logic [2:0]       COLOR_MASK,
`ifdef TRIG_OVERRUN_EN
  input  logic             OVR_CLR,
  output logic             OVERRUN,
  output logic [7:0]       OVR_CNT,
`endif
  output logic             START,
  output logic             END,
  output logic [2:0]       RGB,
  output logic             BUSY,
  output logic             LINE_DONE
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    EXPOSE,
    FINISH,
    GAP,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CLKS);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] exp_r_q, exp_g_q, exp_b_q;
  logic [2:0]       pend_q;   // active colours not yet started
  logic [2:0]       cur_q;    // one-hot colour of the running phase
  logic             start_q, end_q, busy_q, done_q;
  logic [2:0]       rgb_q;

  logic [CNT_W-1:0] exp_cur;
  logic [2:0]       trig_act;
  logic [2:0]       trig_first;
  logic [2:0]       pend_first;

  function automatic logic [2:0] first_col(input logic [2:0] v);
    if (v[2])      return 3'b100;
    else if (v[1]) return 3'b010;
    else if (v[0]) return 3'b001;
    else           return 3'b000;
  endfunction

  always_comb begin
    exp_cur = exp_b_q;
    case (cur_q)
      3'b100:  exp_cur = exp_r_q;
      3'b010:  exp_cur = exp_g_q;
      default: exp_cur = exp_b_q;
    endcase
  end

  // A colour takes part only when enabled and given a nonzero exposure.
  assign trig_act   = COLOR_MASK & {|EXP_R, |EXP_G, |EXP_B};
  assign trig_first = first_col(trig_act);
  assign pend_first = first_col(pend_q);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      exp_r_q <= '0;
      exp_g_q <= '0;
      exp_b_q <= '0;
      pend_q  <= '0;
      cur_q   <= '0;
      start_q <= 1'b0;
      end_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rgb_q   <= '0;
    end else begin
      start_q <= 1'b0;
      end_q   <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (LINE_TRIG) begin
            exp_r_q <= EXP_R;
            exp_g_q <= EXP_G;
            exp_b_q <= EXP_B;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            if (trig_act != 3'b000) begin
              state_q <= SETUP;
              cur_q   <= trig_first;
              rgb_q   <= trig_first;
              pend_q  <= trig_act & ~trig_first;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
              rgb_q   <= '0;
            end
          end
        end
        SETUP: begin
          state_q <= EXPOSE;
          cnt_q   <= CNT_W'(1);
          start_q <= 1'b1;
        end
        EXPOSE: begin
          // Compare before incrementing so an all-ones length never wraps.
          if (cnt_q == exp_cur) begin
            state_q <= FINISH;
            end_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        FINISH: begin
          if (pend_q == 3'b000) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            rgb_q   <= '0;
          end else if (GAP_CLKS == 0) begin
            state_q <= SETUP;
            cur_q   <= pend_first;
            rgb_q   <= pend_first;
            pend_q  <= pend_q & ~pend_first;
          end else begin
            state_q <= GAP;
            cnt_q   <= CNT_W'(1);
            rgb_q   <= '0;
          end
        end
        GAP: begin
          if (cnt_q == GAP_LAST) begin
            state_q <= SETUP;
            cur_q   <= pend_first;
            rgb_q   <= pend_first;
            pend_q  <= pend_q & ~pend_first;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          rgb_q   <= '0;
        end
      endcase
    end
  end

  assign START     = start_q;
  assign END       = end_q;
  assign RGB       = rgb_q;
  assign BUSY      = busy_q;
  assign LINE_DONE = done_q;

`ifdef TRIG_OVERRUN_EN
  logic       ovr_q;
  logic [7:0] ovr_cnt_q;

  // BUSY is high in every state except IDLE, DONE included.
  always_ff @(posedge CLK) begin
    if (RST || OVR_CLR) begin
      ovr_q     <= 1'b0;
      ovr_cnt_q <= '0;
    end else if (LINE_TRIG && busy_q) begin
      ovr_q <= 1'b1;
      if (ovr_cnt_q != 8'hFF) ovr_cnt_q <= ovr_cnt_q + 8'd1;
    end
  end

  assign OVERRUN = ovr_q;
  assign OVR_CNT = ovr_cnt_q;
`endif

endmodule
